// File: rtl/dmux16_buffer.sv
// rtl/dmux16_buffer.sv - two-channel valid/ready elastic buffer behind a 16-bit 1-to-2 demux
// Optional occupancy and drop-error outputs are built when DMUX16_BUFFER_STATUS_EN is defined.
module dmux16_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_out1,
    input  logic [WIDTH-1:0] in_out2,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ch0_data,
    output logic             ch0_valid,
    input  logic             ch0_ready,
    output logic [WIDTH-1:0] ch1_data,
    output logic             ch1_valid,
    input  logic             ch1_ready
`ifdef DMUX16_BUFFER_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0] ch0_count,
    output logic [$clog2(DEPTH):0] ch1_count,
    output logic                   drop_err
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] lane [2];
    logic [WIDTH-1:0] head [2];
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       pop_req;
    logic [1:0]       push;
    logic [1:0]       pop;
`ifdef DMUX16_BUFFER_STATUS_EN
    logic [CW-1:0]    count [2];
`endif

    assign lane[0]  = in_out1;
    assign lane[1]  = in_out2;
    assign pop_req  = {ch1_ready, ch0_ready};
    // A full channel refuses even when it pops this cycle: no pass-through path.
    assign in_ready = in_sel ? ~full[1] : ~full[0];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        localparam logic CH_SEL = 1'(c);

        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [CW-1:0]    cnt;

        assign full[c]  = (cnt == FULL_COUNT);
        assign empty[c] = (cnt == '0);
        assign push[c]  = in_valid & in_ready & (in_sel == CH_SEL);
        assign pop[c]   = ~empty[c] & pop_req[c];
        assign head[c]  = empty[c] ? '0 : mem[rd_ptr];
`ifdef DMUX16_BUFFER_STATUS_EN
        assign count[c] = cnt;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[c]) begin
                    mem[wr_ptr] <= lane[c];
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop[c]) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push[c], pop[c]})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign ch0_data  = head[0];
    assign ch0_valid = ~empty[0];
    assign ch1_data  = head[1];
    assign ch1_valid = ~empty[1];

`ifdef DMUX16_BUFFER_STATUS_EN
    logic rej_q;
    logic rej_sel_q;
    logic rej;

    assign rej       = in_valid & ~in_ready;
    assign ch0_count = count[0];
    assign ch1_count = count[1];

    // Sticky: a producer that keeps retrying the same full channel back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            rej_q     <= 1'b0;
            rej_sel_q <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            rej_q     <= rej;
            rej_sel_q <= in_sel;
            if (rej && rej_q && (in_sel == rej_sel_q)) begin
                drop_err <= 1'b1;
            end
        end
    end
`endif

endmodule
